logic_slice_unit: RTL and testbench
===================================

// Module: logic_slice_unit
// PURPOSE
//   Parametrised, slice-serial bitwise logic unit with valid/ready handshakes on both sides.
//   Latches two WIDTH-bit operands and an opcode, then evaluates SLICE bits per cycle.
//   Holds the result until the consumer takes it.
//   Successor to the fixed 32-bit gate-level NOR/AND/INV/OR blocks, for the ALU's shared logic path.
// PARAMETERS
//   WIDTH  32  operand/result width; must be a multiple of SLICE (elaboration error otherwise)
//   SLICE   8  bits evaluated per cycle; NSLICE = WIDTH/SLICE; SLICE==WIDTH gives single-cycle op
// PORTS
//   CLK        in   1      clock; all state on rising edge
//   RST        in   1      asynchronous, active-low reset
//   IN_VALID   in   1      operand/opcode valid
//   IN_READY   out  1      unit can accept (state IDLE)
//   OPSEL      in   3      opcode, sampled with A/B on input handshake
//   A          in   WIDTH  operand A
//   B          in   WIDTH  operand B
//   OUT_VALID  out  1      Y holds a complete result
//   OUT_READY  in   1      consumer accepts Y
//   Y          out  WIDTH  result register
//   ZERO       out  1      result-is-zero flag (only with LOGIC_ZERO_FLAG_EN)
// BEHAVIOUR
//   Interface: one clock, CLK; reset is asynchronous and active-low, RST.
//   - RST low at any time, including mid-operation: state IDLE, slice counter 0, IN_READY=1,
//     OUT_VALID=0, Y=0, ZERO=0. Any in-flight operation is discarded; no partial result is ever presented.
//   - Opcodes: 000 AND, 001 OR, 010 NOR, 011 NAND, 100 XOR, 101 XNOR, 110 NOT A, 111 PASS A.
//     All 8 codes are defined. B is ignored for 110 and 111.
//   - FSM IDLE -> RUN -> HOLD -> IDLE.
//   - IDLE: IN_READY=1. On IN_VALID&IN_READY, latch A, B, OPSEL into internal regs; cnt<=0; go RUN.
//   - RUN: IN_READY=0. Each cycle computes slice cnt and writes Y[cnt*SLICE +: SLICE]; cnt++.
//     On the edge writing slice NSLICE-1, go HOLD and set OUT_VALID=1.
//     Latency: OUT_VALID is high NSLICE cycles after the accept edge.
//   - HOLD: OUT_VALID=1; Y (and ZERO) are stable. IN_READY=0, so IN_VALID is ignored.
//     On OUT_VALID&OUT_READY: OUT_VALID<=0, go IDLE.
//     IN_READY rises the cycle after the output handshake.
//   - Throughput: one op per NSLICE+2 cycles with no backpressure. No combinational path from
//     OUT_READY to IN_READY.
//   - Input pins A/B/OPSEL may change freely after acceptance; only latched copies are used.
//   - Y retains the last result in IDLE. Y is not cleared on output handshake.
//     Y is valid only while OUT_VALID=1.
//   - cnt width is max(1,$clog2(NSLICE)). cnt never exceeds NSLICE-1.
// CONFIGURATION
//   LOGIC_ZERO_FLAG_EN defined:
//     - ZERO port exists. It is accumulated per slice: cleared to 1 on accept, ANDed with
//       ~|slice each RUN cycle.
//     - ZERO equals (Y==0) whenever OUT_VALID=1; it holds in HOLD and IDLE.
//   LOGIC_ZERO_FLAG_EN undefined: ZERO port and its accumulator are absent; all else identical.
// STRUCTURE
//   Shared package logic_unit_pkg holds:
//     - OPSEL width and the 8 opcode localparams
//     - FSM state encodings (IDLE/RUN/HOLD)
//   Sub-module logic_slice: combinational SLICE-bit op (inputs a, b, opsel; output y),
//   instantiated once. Top level holds FSM, counter, operand regs, Y and ZERO regs.
// TESTING (WIDTH=32, SLICE=8 unless noted)
//   1. Hold RST low, then release -> IN_READY=1, OUT_VALID=0, Y=0, ZERO=0.
//   2. AND, A=F0F0_1234, B=FF00_FFFF, OUT_READY=1 -> OUT_VALID 4 cycles after accept,
//      Y=F000_1234, ZERO=0.
//   3. NOR 0,0 -> Y=FFFF_FFFF. Then NOT A with A=FFFF_FFFF -> Y=0000_0000, ZERO=1.
//   4. OUT_READY low 5 cycles in HOLD, IN_VALID held high with new operands ->
//      Y and OUT_VALID stable, IN_READY=0, new op accepted only after drain.
//   5. RST pulsed low after 2 RUN cycles of XOR -> IDLE, OUT_VALID=0, Y=0;
//      no result appears later; next op completes normally.
//   6. SLICE=32 instance: XOR AAAA_5555 ^ FFFF_0000 -> Y=5555_5555, OUT_VALID 1 cycle after accept.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Opcode and FSM state encodings shared by the slice-serial logic unit and its slice datapath.
package logic_unit_pkg;

   localparam int OPSEL_W = 3;

   localparam logic [OPSEL_W-1:0] OP_AND  = 3'b000;
   localparam logic [OPSEL_W-1:0] OP_OR   = 3'b001;
   localparam logic [OPSEL_W-1:0] OP_NOR  = 3'b010;
   localparam logic [OPSEL_W-1:0] OP_NAND = 3'b011;
   localparam logic [OPSEL_W-1:0] OP_XOR  = 3'b100;
   localparam logic [OPSEL_W-1:0] OP_XNOR = 3'b101;
   localparam logic [OPSEL_W-1:0] OP_NOTA = 3'b110;
   localparam logic [OPSEL_W-1:0] OP_PASS = 3'b111;

   localparam int STATE_W = 2;

   localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
   localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
   localparam logic [STATE_W-1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/logic_slice.sv
// Combinational SLICE-bit bitwise operator; B is ignored by NOT A and PASS A.
module logic_slice
   import logic_unit_pkg::*;
#(
   parameter int SLICE = 8
) (
   input  logic [SLICE-1:0]   a,
   input  logic [SLICE-1:0]   b,
   input  logic [OPSEL_W-1:0] opsel,
   output logic [SLICE-1:0]   y
);

   always_comb begin
      y = '0;
      case (opsel)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_NOR:  y = ~(a | b);
         OP_NAND: y = ~(a & b);
         OP_XOR:  y = a ^ b;
         OP_XNOR: y = ~(a ^ b);
         OP_NOTA: y = ~a;
         OP_PASS: y = a;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/logic_slice_unit.sv
// Slice-serial logic unit: accepts A/B/OPSEL, evaluates SLICE bits per cycle, holds Y until taken.
// Optional result-is-zero flag and ZERO port enabled by defining LOGIC_ZERO_FLAG_EN.
module logic_slice_unit
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               IN_VALID,
   output logic               IN_READY,
   input  logic [OPSEL_W-1:0] OPSEL,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               OUT_VALID,
   input  logic               OUT_READY,
   output logic [WIDTH-1:0]   Y
`ifdef LOGIC_ZERO_FLAG_EN
   ,
   output logic               ZERO
`endif
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

   if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_param_check
      $error("logic_slice_unit: WIDTH must be a non-zero multiple of SLICE");
   end

   logic [STATE_W-1:0] state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [OPSEL_W-1:0] op_q, op_d;
   logic [WIDTH-1:0]   y_q, y_d;
   logic               out_valid_q, out_valid_d;
`ifdef LOGIC_ZERO_FLAG_EN
   logic               zero_q, zero_d;
`endif

   logic [SLICE-1:0] a_sl, b_sl, y_sl;

   // Operand slice selected by the counter; constant part-selects keep every index in range.
   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int i = 0; i < NSLICE; i++) begin
         if (cnt_q == CNT_W'(i)) begin
            a_sl = a_q[i*SLICE +: SLICE];
            b_sl = b_q[i*SLICE +: SLICE];
         end
      end
   end

   logic_slice #(
      .SLICE (SLICE)
   ) u_slice (
      .a     (a_sl),
      .b     (b_sl),
      .opsel (op_q),
      .y     (y_sl)
   );

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      y_d         = y_q;
      out_valid_d = out_valid_q;
`ifdef LOGIC_ZERO_FLAG_EN
      zero_d      = zero_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (IN_VALID) begin
               a_d     = A;
               b_d     = B;
               op_d    = OPSEL;
               cnt_d   = '0;
               state_d = ST_RUN;
`ifdef LOGIC_ZERO_FLAG_EN
               zero_d  = 1'b1;
`endif
            end
         end

         ST_RUN: begin
            for (int i = 0; i < NSLICE; i++) begin
               if (cnt_q == CNT_W'(i)) begin
                  y_d[i*SLICE +: SLICE] = y_sl;
               end
            end
`ifdef LOGIC_ZERO_FLAG_EN
            zero_d = zero_q & ~(|y_sl);
`endif
            // The edge writing the last slice presents the result; cnt wraps so it never passes NSLICE-1.
            if (cnt_q == CNT_LAST) begin
               cnt_d       = '0;
               state_d     = ST_HOLD;
               out_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_HOLD: begin
            if (OUT_READY) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         y_q         <= '0;
         out_valid_q <= 1'b0;
`ifdef LOGIC_ZERO_FLAG_EN
         zero_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         y_q         <= y_d;
         out_valid_q <= out_valid_d;
`ifdef LOGIC_ZERO_FLAG_EN
         zero_q      <= zero_d;
`endif
      end
   end

   // IN_READY depends on state only, so there is no combinational path from OUT_READY.
   assign IN_READY  = (state_q == ST_IDLE);
   assign OUT_VALID = out_valid_q;
   assign Y         = y_q;
`ifdef LOGIC_ZERO_FLAG_EN
   assign ZERO      = zero_q;
`endif

endmodule

// File: tb/tb_logic_slice_unit.sv
// Self-checking bench for logic_slice_unit (WIDTH=32/SLICE=8 and a single-cycle SLICE=32 instance).
module tb_logic_slice_unit;

   localparam int WIDTH  = 32;
   localparam int NSLICE = 4;

   logic             clk;
   logic             rst_n;
   logic             in_valid, in_ready, out_valid, out_ready;
   logic [2:0]       opsel;
   logic [WIDTH-1:0] a, b, y;
   logic             in_valid2, in_ready2, out_valid2, out_ready2;
   logic [2:0]       opsel2;
   logic [WIDTH-1:0] a2, b2, y2;
`ifdef LOGIC_ZERO_FLAG_EN
   logic             zero, zero2;
`endif

   int checks = 0;
   int errors = 0;

   logic_slice_unit #(.WIDTH(WIDTH), .SLICE(8)) dut (
      .CLK(clk), .RST(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready), .OPSEL(opsel),
      .A(a), .B(b), .OUT_VALID(out_valid), .OUT_READY(out_ready), .Y(y)
`ifdef LOGIC_ZERO_FLAG_EN
      , .ZERO(zero)
`endif
   );

   logic_slice_unit #(.WIDTH(WIDTH), .SLICE(32)) dut1 (
      .CLK(clk), .RST(rst_n), .IN_VALID(in_valid2), .IN_READY(in_ready2), .OPSEL(opsel2),
      .A(a2), .B(b2), .OUT_VALID(out_valid2), .OUT_READY(out_ready2), .Y(y2)
`ifdef LOGIC_ZERO_FLAG_EN
      , .ZERO(zero2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: whole-word result straight from the opcode table.
   function automatic logic [WIDTH-1:0] model(input logic [2:0] op, input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] z);
      case (op)
         3'd0:    return x & z;
         3'd1:    return x | z;
         3'd2:    return ~(x | z);
         3'd3:    return ~(x & z);
         3'd4:    return x ^ z;
         3'd5:    return ~(x ^ z);
         3'd6:    return ~x;
         default: return x;
      endcase
   endfunction

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one operation in IDLE, step through the accept edge, then scramble the pins.
   task automatic start_op(input logic [2:0] op, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] z);
      opsel    = op;
      a        = x;
      b        = z;
      in_valid = 1'b1;
      check("in_ready_before_accept", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      opsel    = 3'($urandom);
      a        = $urandom;
      b        = $urandom;
   endtask

   task automatic wait_result(input string tag, input logic [WIDTH-1:0] exp_y);
      int lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(NSLICE));
      check({tag, "_y"}, y, exp_y);
      check({tag, "_in_ready_hold"}, 32'(in_ready), 32'd0);
`ifdef LOGIC_ZERO_FLAG_EN
      check({tag, "_zero"}, 32'(zero), 32'(exp_y == '0));
`endif
   endtask

   task automatic drain(input string tag, input logic [WIDTH-1:0] exp_y);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_out_valid_after_drain"}, 32'(out_valid), 32'd0);
      check({tag, "_in_ready_after_drain"}, 32'(in_ready), 32'd1);
      check({tag, "_y_retained"}, y, exp_y);
   endtask

   initial begin
      logic [2:0]       op;
      logic [WIDTH-1:0] x, z, exp_y, new_x, new_z;
      int               stall;
      logic             seen_valid;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; opsel = '0; a = '0; b = '0;
      in_valid2 = 1'b0; out_ready2 = 1'b0; opsel2 = '0; a2 = '0; b2 = '0;

      // Reset state
      #23;
      rst_n = 1'b1;
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_y", y, 32'd0);
`ifdef LOGIC_ZERO_FLAG_EN
      check("rst_zero", 32'(zero), 32'd0);
`endif

      // Directed: AND, NOR of zeros, NOT A of all-ones
      start_op(3'd0, 32'hF0F0_1234, 32'hFF00_FFFF);
      wait_result("and", 32'hF000_1234);
      drain("and", 32'hF000_1234);
      start_op(3'd2, 32'h0, 32'h0);
      wait_result("nor", 32'hFFFF_FFFF);
      drain("nor", 32'hFFFF_FFFF);
      start_op(3'd6, 32'hFFFF_FFFF, 32'h1234_5678);
      wait_result("nota", 32'h0);
      drain("nota", 32'h0);

      // Backpressure in HOLD with a new operation waiting on the input
      start_op(3'd1, 32'h1200_0034, 32'h0056_7800);
      wait_result("bp", 32'h1256_7834);
      new_x = $urandom; new_z = $urandom;
      opsel = 3'd5; a = new_x; b = new_z; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_stall_out_valid", 32'(out_valid), 32'd1);
         check("bp_stall_in_ready", 32'(in_ready), 32'd0);
         check("bp_stall_y", y, 32'h1256_7834);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_drain_in_ready", 32'(in_ready), 32'd1);
      check("bp_drain_out_valid", 32'(out_valid), 32'd0);
      tick();
      in_valid = 1'b0; a = $urandom; b = $urandom; opsel = 3'($urandom);
      wait_result("bp_next", ~(new_x ^ new_z));
      drain("bp_next", ~(new_x ^ new_z));

      // Reset during RUN discards the in-flight operation
      start_op(3'd4, 32'hDEAD_BEEF, 32'h0F0F_0F0F);
      tick();
      tick();
      rst_n = 1'b0;
      #2;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_y", y, 32'd0);
      rst_n = 1'b1;
      seen_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (out_valid) seen_valid = 1'b1;
      end
      check("midrst_no_late_result", 32'(seen_valid), 32'd0);
      start_op(3'd3, 32'hFFFF_0000, 32'hFF00_FF00);
      wait_result("after_rst", 32'h00FF_FFFF);
      drain("after_rst", 32'h00FF_FFFF);

      // Randomized operations against the model, with random HOLD stalls
      for (int n = 0; n < 24; n++) begin
         op    = 3'($urandom);
         x     = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         z     = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         exp_y = model(op, x, z);
         stall = $urandom_range(0, 3);
         start_op(op, x, z);
         wait_result("rand", exp_y);
         for (int s = 0; s < stall; s++) begin
            tick();
            check("rand_stall_y", y, exp_y);
         end
         drain("rand", exp_y);
      end

      // Single-cycle instance: SLICE == WIDTH
      opsel2 = 3'd4; a2 = 32'hAAAA_5555; b2 = 32'hFFFF_0000; in_valid2 = 1'b1;
      check("s32_in_ready", 32'(in_ready2), 32'd1);
      tick();
      in_valid2 = 1'b0; a2 = $urandom; b2 = $urandom;
      check("s32_out_valid_after_1", 32'(out_valid2), 32'd0);
      tick();
      check("s32_out_valid", 32'(out_valid2), 32'd1);
      check("s32_y", y2, 32'h5555_5555);
`ifdef LOGIC_ZERO_FLAG_EN
      check("s32_zero", 32'(zero2), 32'd0);
`endif
      out_ready2 = 1'b1;
      tick();
      out_ready2 = 1'b0;
      check("s32_drain_out_valid", 32'(out_valid2), 32'd0);
      check("s32_drain_in_ready", 32'(in_ready2), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
